cmp_operand_stage: RTL and testbench
====================================

CMP_OPERAND_STAGE -- requirements
Module: cmp_operand_stage

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, number of cycles comparator enable is held before sampling (legal 1-15).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port data_in  input  8  operand load bus.
REQ-005 SHALL have port ld_p  input  1  load data_in into P operand register.
REQ-006 SHALL have port ld_q  input  1  load data_in into Q operand register.
REQ-007 SHALL have port start  input  1  compare request.
REQ-008 SHALL have port eq_n  input  1  active-low P=Q result from downstream 8-bit identity comparator.
REQ-009 SHALL have port p_out  output  8  registered P operand to comparator P pins.
REQ-010 SHALL have port q_out  output  8  registered Q operand to comparator Q pins.
REQ-011 SHALL have port g_n  output  1  active-low comparator enable.
REQ-012 SHALL have port busy  output  1  compare in progress.
REQ-013 SHALL have port done  output  1  one-cycle compare-complete pulse.
REQ-014 SHALL have port match  output  1  compare result flag.
REQ-015 SHALL have port match_count  output  8  count of matching compares.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, SAMPLE; all outputs registered.
REQ-017 IDLE: start=1 at edge N -> SETTLE, busy=1, g_n=0 after edge N.
REQ-018 SETTLE: g_n=0; remains exactly SETTLE_CYCLES cycles, then -> SAMPLE.
REQ-019 SAMPLE: g_n=0; at its closing edge eq_n sampled, match<=~eq_n, -> IDLE, g_n=1, busy=0, done=1 for exactly one cycle.
REQ-020 Latency SHALL be: done high in cycle after edge N+SETTLE_CYCLES+1.
REQ-021 ld_p/ld_q SHALL take effect only in IDLE; ignored while busy=1.
REQ-022 ld_p and ld_q asserted together SHALL load both registers with the same data_in.
REQ-023 start with ld_p/ld_q in same IDLE cycle: load and start both accepted; compare uses newly loaded values.
REQ-024 start while busy SHALL be ignored (no queuing).
REQ-025 match_count SHALL increment by 1 per sampled match, saturating at 255 (no wrap).
REQ-026 g_n SHALL be 1 whenever state is IDLE.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, p_out=q_out=0x00, g_n=1, busy=0, done=0, match=0, match_count=0, including mid-compare; no done pulse issued for an aborted compare.

Configuration
REQ-028 Macro CMP_STICKY_EN defined: match SHALL be sticky (OR of all results) until next accepted ld_p or ld_q clears it to 0.
REQ-029 Macro CMP_STICKY_EN undefined: match SHALL reflect only the most recent completed compare; loads do not alter it.

Verification
REQ-030 SETTLE_CYCLES=1; load P=0xA5, Q=0xA5, start at edge 0, model comparator -> g_n=0 cycles 1-2, done=1 after edge 2, match=1, match_count=1.
REQ-031 P=0x3C, Q=0x3D, compare -> done pulse, match=0, match_count unchanged; with CMP_STICKY_EN after prior match, match stays 1 until ld_q.
REQ-032 ld_p=0x55 and start asserted during SETTLE -> p_out unchanged, no second done pulse.
REQ-033 256 consecutive matching compares -> match_count=0xFF, stays 0xFF after 257th.
REQ-034 rst_n low during SETTLE -> g_n=1, busy=0, all outputs zero asynchronously, no done pulse after release.
REQ-035 ld_p, ld_q, start same cycle with data_in=0x81 -> p_out=q_out=0x81, compare yields match=1.

Source files
------------

// File: rtl/cmp_operand_stage.sv
// -----------------------------------------------------------------------------
// cmp_operand_stage
//
// Operand staging and sequencing for an external 8-bit identity comparator.
// The block holds two operand registers (P, Q) that drive the comparator
// pins. On a compare request it asserts the comparator enable and holds it
// for SETTLE_CYCLES cycles plus one sample cycle. At the end of the sample
// cycle it captures the comparator result, pulses done, and updates a
// saturating count of matches.
//
// Parameters
//   SETTLE_CYCLES  cycles g_n is held low before the sample cycle (1..15)
//
// Ports
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   data_in[7:0] in   operand load bus
//   ld_p         in   load data_in into P (accepted only when idle)
//   ld_q         in   load data_in into Q (accepted only when idle)
//   start        in   compare request (ignored while busy)
//   eq_n         in   active-low P=Q result from the comparator
//   p_out[7:0]   out  registered P operand
//   q_out[7:0]   out  registered Q operand
//   g_n          out  active-low comparator enable
//   busy         out  compare in progress
//   done         out  one-cycle compare-complete pulse
//   match        out  compare result flag
//   match_count  out  saturating count of matching compares
//
// Build option
//   CMP_STICKY_EN  when defined, match accumulates (OR) across compares and
//                  is cleared by any accepted ld_p/ld_q. When undefined,
//                  match shows only the latest compare result.
// -----------------------------------------------------------------------------
module cmp_operand_stage #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       ld_p,
    input  logic       ld_q,
    input  logic       start,
    input  logic       eq_n,
    output logic [7:0] p_out,
    output logic [7:0] q_out,
    output logic       g_n,
    output logic       busy,
    output logic       done,
    output logic       match,
    output logic [7:0] match_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [7:0] p_reg, p_next;
    logic [7:0] q_reg, q_next;
    logic       g_n_reg, g_n_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       match_reg, match_next;
    logic [7:0] count_reg, count_next;
    logic       result;

    // comparator reports equality active-low
    assign result = ~eq_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            p_reg     <= 8'h00;
            q_reg     <= 8'h00;
            g_n_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            match_reg <= 1'b0;
            count_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            p_reg     <= p_next;
            q_reg     <= q_next;
            g_n_reg   <= g_n_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            match_reg <= match_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        p_next     = p_reg;
        q_next     = q_reg;
        g_n_next   = g_n_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        match_next = match_reg;
        count_next = count_reg;

        case (state_reg)
            IDLE: begin
                g_n_next  = 1'b1;
                busy_next = 1'b0;
                // loads and start in the same cycle are both taken; the
                // comparator sees the new operands from the first SETTLE cycle
                if (ld_p) p_next = data_in;
                if (ld_q) q_next = data_in;
`ifdef CMP_STICKY_EN
                if (ld_p || ld_q) match_next = 1'b0;
`endif
                if (start) begin
                    state_next = SETTLE;
                    cnt_next   = 4'd0;
                    g_n_next   = 1'b0;
                    busy_next  = 1'b1;
                end
            end

            SETTLE: begin
                if (cnt_reg == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            SAMPLE: begin
                state_next = IDLE;
                g_n_next   = 1'b1;
                busy_next  = 1'b0;
                done_next  = 1'b1;
`ifdef CMP_STICKY_EN
                match_next = match_reg | result;
`else
                match_next = result;
`endif
                if (result && (count_reg != 8'hFF)) begin
                    count_next = count_reg + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
                g_n_next   = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign p_out       = p_reg;
    assign q_out       = q_reg;
    assign g_n         = g_n_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign match       = match_reg;
    assign match_count = count_reg;

endmodule

// File: tb/tb_cmp_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_cmp_operand_stage
//
// Directed bench for cmp_operand_stage (SETTLE_CYCLES = 1). Each compare
// request pushes its expected {match, match_count, p_out, q_out} into a
// queue; a monitor pops and compares whenever done is seen. The downstream
// identity comparator is modelled behaviourally, with an override to force
// a "not equal" answer.
// -----------------------------------------------------------------------------
module tb_cmp_operand_stage;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       ld_p;
    logic       ld_q;
    logic       start;
    logic       eq_n;
    logic [7:0] p_out;
    logic [7:0] q_out;
    logic       g_n;
    logic       busy;
    logic       done;
    logic       match;
    logic [7:0] match_count;

    logic force_ne;

    typedef struct packed {
        logic       m;
        logic [7:0] cnt;
        logic [7:0] p;
        logic [7:0] q;
    } exp_t;

    exp_t exp_q[$];

    int n_checks;
    int n_fail;

`ifdef CMP_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    cmp_operand_stage #(.SETTLE_CYCLES(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .ld_p        (ld_p),
        .ld_q        (ld_q),
        .start       (start),
        .eq_n        (eq_n),
        .p_out       (p_out),
        .q_out       (q_out),
        .g_n         (g_n),
        .busy        (busy),
        .done        (done),
        .match       (match),
        .match_count (match_count)
    );

    // downstream identity comparator: eq_n low when P == Q
    assign eq_n = (p_out != q_out) | force_ne;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // drive one cycle of inputs at negedge, return 1 time unit after the edge
    task automatic cyc(input logic lp, input logic lq, input logic [7:0] d, input logic st);
        @(negedge clk);
        ld_p    = lp;
        ld_q    = lq;
        data_in = d;
        start   = st;
        @(posedge clk);
        #1;
        ld_p  = 1'b0;
        ld_q  = 1'b0;
        start = 1'b0;
    endtask

    task automatic push(input logic m, input logic [7:0] cnt, input logic [7:0] p, input logic [7:0] q);
        exp_t e;
        e.m = m; e.cnt = cnt; e.p = p; e.q = q;
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done within 20 cycles, expected a pulse");
        end
    endtask

    task automatic idle_cycles(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check(name, {30'd0, done, busy}, 32'd0);
        end
    endtask

    // scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse");
                end else begin
                    e = exp_q.pop_front();
                    check("sb_match", {31'd0, match}, {31'd0, e.m});
                    check("sb_count", {24'd0, match_count}, {24'd0, e.cnt});
                    check("sb_operands", {16'd0, p_out, q_out}, {16'd0, e.p, e.q});
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        data_in  = 8'h00;
        ld_p     = 1'b0;
        ld_q     = 1'b0;
        start    = 1'b0;
        force_ne = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {3'd0, p_out, q_out, g_n, busy, done, match, match_count},
              {3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;

        // basic match with latency/g_n timing
        cyc(1'b1, 1'b0, 8'hA5, 1'b0);
        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        check("idle_g_n", {31'd0, g_n}, 32'd1);
        push(1'b1, 8'd1, 8'hA5, 8'hA5);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);                 // edge N
        check("cyc1_gn_busy_done", {29'd0, g_n, busy, done}, {29'd0, 3'b010});
        @(posedge clk); #1;                            // edge N+1
        check("cyc2_gn_busy_done", {29'd0, g_n, busy, done}, {29'd0, 3'b010});
        @(posedge clk); #1;                            // edge N+2
        check("done_cycle", {29'd0, g_n, busy, done}, {29'd0, 3'b101});
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // mismatch; in sticky build the load clears match first
        cyc(1'b1, 1'b0, 8'h3C, 1'b0);
        cyc(1'b0, 1'b1, 8'h3D, 1'b0);
        check("match_after_load", {31'd0, match}, {31'd0, !STICKY});
        push(1'b0, 8'd1, 8'h3C, 8'h3D);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        wait_done();

        // match then forced miss: sticky keeps 1, plain drops to 0
        cyc(1'b0, 1'b1, 8'h3C, 1'b0);
        push(1'b1, 8'd2, 8'h3C, 8'h3C);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        wait_done();
        force_ne = 1'b1;
        push(STICKY, 8'd2, 8'h3C, 8'h3C);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        wait_done();
        force_ne = 1'b0;
        cyc(1'b0, 1'b1, 8'h3C, 1'b0);
        check("match_after_ld_q", {31'd0, match}, 32'd0);

        // load and start during SETTLE are ignored
        push(1'b1, 8'd3, 8'h3C, 8'h3C);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 1'b0, 8'h55, 1'b1);
        check("p_hold_busy", {24'd0, p_out}, {24'd0, 8'h3C});
        wait_done();
        idle_cycles(4, "no_second_done");

        // simultaneous ld_p, ld_q, start
        push(1'b1, 8'd4, 8'h81, 8'h81);
        cyc(1'b1, 1'b1, 8'h81, 1'b1);
        check("both_loaded", {16'd0, p_out, q_out}, {16'd0, 8'h81, 8'h81});
        wait_done();

        // reset during SETTLE
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check("in_settle_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {3'd0, p_out, q_out, g_n, busy, done, match, match_count},
              {3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(4, "no_done_after_abort");

        // saturation: 257 matching compares of P=Q=0
        for (int i = 0; i < 257; i++) begin
            push(1'b1, (i >= 254) ? 8'hFF : 8'(i + 1), 8'h00, 8'h00);
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            wait_done();
        end
        @(negedge clk);
        @(negedge clk);
        check("final_count", {24'd0, match_count}, 32'h0000_00FF);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
